exec_div_sequencer: RTL and testbench
=====================================

// Module: exec_div_sequencer
// PURPOSE
//  Multi-cycle integer divide sequencer beside the execute-stage ALU. Accepts DIV/DIVU/REM/REMU
//  from the decode->execute pipe register and runs an iterative restoring divider. While busy it
//  raises stall to the pipeline controller, then presents a one-cycle result for execute to latch
//  into the memory-access pipe register. Abortable by branch-mispredict flush.
// PARAMETERS
//  XLEN             32  operand/result width
//  STEPS_PER_CYCLE  1   quotient bits resolved per cycle; 1 or 2 only; must divide XLEN
// PORTS
//  clk           in   1     clock; all state updates on negedge clk, same edge as pipe registers
//  rst           in   1     synchronous reset, active-low
//  req_valid     in   1     divide op present in execute stage; held by stall until done
//  req_op        in   2     0=DIV 1=DIVU 2=REM 3=REMU
//  rs1           in   XLEN  dividend (already bypassed)
//  rs2           in   XLEN  divisor (already bypassed)
//  flush         in   1     branch-mispredict flush from controller
//  stall         out  1     freeze fetch/decode/execute pipe registers
//  result_valid  out  1     result valid this cycle
//  result        out  XLEN  quotient or remainder per req_op
// BEHAVIOUR
//  - States: IDLE, BUSY, DONE. Counter cnt: $clog2(XLEN/STEPS_PER_CYCLE)+1 bits.
//  - Reset (rst==0 at the edge): state=IDLE, cnt=0, rem/quo/divisor regs=0, sign flags=0,
//    result_valid=0, result=0, stall=0 once reset is released.
//  - stall = req_valid & (state!=DONE) & ~flush (combinational).
//  - IDLE, req_valid: latch op; take |rs1|,|rs2| for signed ops; record
//    neg_q = rs1[XLEN-1]^rs2[XLEN-1] and neg_r = rs1[XLEN-1] (signed ops only).
//    rs2==0 or (signed & rs1==MIN & rs2==-1) -> DONE next edge (fast path); else BUSY, cnt=XLEN/S.
//  - BUSY: per cycle, S restoring steps: shift {rem,quo} left 1, trial subtract divisor,
//    set quo LSB if no borrow. cnt-=1; cnt==1 at edge -> DONE.
//  - DONE: result_valid=1, stall=0; result = signed-corrected quo (op 0/1) or rem (op 2/3).
//    Next edge -> IDLE unconditionally.
//  - Special results: div-by-zero: quotient=all ones, remainder=rs1.
//    Overflow (MIN/-1): quotient=MIN, remainder=0.
//  - Latency: normal = 1 + XLEN/S stall cycles, then 1 DONE cycle (S=1: 33 stall cycles);
//    fast path = 1 stall cycle then DONE.
//  - flush in any state: next edge -> IDLE, cnt=0, no result_valid; stall=0 during the flush cycle.
//  - req_valid dropped while BUSY (illegal except with flush): abort to IDLE at next edge.
//  - Back-to-back divides: DONE->IDLE, so the next request is accepted one cycle after DONE.
//  - rst mid-operation: as reset; no result emitted.
// CONFIGURATION
//  EXEC_DIV_RESULT_REUSE_EN
//   defined: keep last completed rs1, rs2, signedness plus final quo/rem (valid bit, cleared on
//    reset/flush). An IDLE request with matching rs1, rs2 and signedness (DIV<->REM,
//    DIVU<->REMU or repeat) -> DONE next edge, 1 stall cycle, result from stored regs.
//   undefined: no operand store; every request takes the full or fast path.
// TESTING
//  - DIVU rs1=100 rs2=7 -> stall 33 cycles, then result_valid=1, result=14, stall=0.
//  - REM rs1=-7 rs2=2 -> result=-1 (0xFFFFFFFF); DIV same operands -> result=-3 (0xFFFFFFFD).
//  - DIV rs1=5 rs2=0 -> 1 stall cycle, result=0xFFFFFFFF; REMU 5/0 -> result=5.
//  - DIV rs1=0x80000000 rs2=0xFFFFFFFF -> 1 stall cycle, result=0x80000000; REM -> result=0.
//  - DIVU 100/7 with flush at BUSY cycle 10 -> IDLE next edge, stall=0, result_valid never set;
//    next DIVU 9/3 -> result=3.
//  - With EXEC_DIV_RESULT_REUSE_EN: DIV 100/7 then REM 100/7 -> second op 1 stall cycle, result=2;
//    without macro -> 33 stall cycles, result=2.

Source files
------------

// File: rtl/exec_div_sequencer_if.sv
// Divide-sequencer request/result bundle between the execute stage and the divider.
interface exec_div_sequencer_if #(
  parameter int unsigned XLEN = 32
);
  logic            req_valid;
  logic [1:0]      req_op;
  logic [XLEN-1:0] rs1;
  logic [XLEN-1:0] rs2;
  logic            flush;
  logic            stall;
  logic            result_valid;
  logic [XLEN-1:0] result;

  modport master (
    output req_valid, req_op, rs1, rs2, flush,
    input  stall, result_valid, result
  );

  modport slave (
    input  req_valid, req_op, rs1, rs2, flush,
    output stall, result_valid, result
  );
endinterface

// File: rtl/exec_div_sequencer.sv
// Iterative restoring divider for DIV/DIVU/REM/REMU beside the execute-stage ALU.
// Optional EXEC_DIV_RESULT_REUSE_EN: reuse the last completed result for matching operands.
module exec_div_sequencer #(
  parameter int unsigned XLEN            = 32,
  parameter int unsigned STEPS_PER_CYCLE = 1
) (
  input logic                 clk,
  input logic                 rst,
  exec_div_sequencer_if.slave bus
);

  localparam int unsigned      CNT_W    = $clog2(XLEN / STEPS_PER_CYCLE) + 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(XLEN / STEPS_PER_CYCLE);
  localparam logic [XLEN-1:0]  MIN_VAL  = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t          state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [XLEN-1:0] rem, rem_n;
  logic [XLEN-1:0] quo, quo_n;
  logic [XLEN-1:0] dvs, dvs_n;
  logic            neg_q, neg_q_n;
  logic            neg_r, neg_r_n;
  logic [1:0]      op, op_n;

  logic            signed_op;
  logic            is_ovf;
  logic [XLEN-1:0] abs_a, abs_b;
  logic [XLEN-1:0] q_fin, r_fin;
  logic [XLEN:0]   shifted;
  logic [XLEN-1:0] work_rem, work_quo;

`ifdef EXEC_DIV_RESULT_REUSE_EN
  logic            last_valid, last_valid_n;
  logic [XLEN-1:0] last_a, last_a_n;
  logic [XLEN-1:0] last_b, last_b_n;
  logic            last_sgn, last_sgn_n;
  logic [XLEN-1:0] last_q, last_q_n;
  logic [XLEN-1:0] last_r, last_r_n;
  logic [XLEN-1:0] cur_a, cur_a_n;
  logic [XLEN-1:0] cur_b, cur_b_n;
  logic            cur_sgn, cur_sgn_n;
  logic            reuse_hit;

  assign reuse_hit = last_valid && (bus.rs1 == last_a) && (bus.rs2 == last_b) &&
                     (signed_op == last_sgn);
`endif

  assign signed_op = ~bus.req_op[0];
  assign is_ovf    = signed_op && (bus.rs1 == MIN_VAL) && (bus.rs2 == '1);
  assign abs_a     = (signed_op && bus.rs1[XLEN-1]) ? -bus.rs1 : bus.rs1;
  assign abs_b     = (signed_op && bus.rs2[XLEN-1]) ? -bus.rs2 : bus.rs2;
  assign q_fin     = neg_q ? -quo : quo;
  assign r_fin     = neg_r ? -rem : rem;

  assign bus.stall        = bus.req_valid && (state != DONE) && !bus.flush;
  assign bus.result_valid = (state == DONE) && !bus.flush;
  assign bus.result       = (state == DONE) ? (op[1] ? r_fin : q_fin) : '0;

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    rem_n    = rem;
    quo_n    = quo;
    dvs_n    = dvs;
    neg_q_n  = neg_q;
    neg_r_n  = neg_r;
    op_n     = op;
`ifdef EXEC_DIV_RESULT_REUSE_EN
    last_valid_n = last_valid;
    last_a_n     = last_a;
    last_b_n     = last_b;
    last_sgn_n   = last_sgn;
    last_q_n     = last_q;
    last_r_n     = last_r;
    cur_a_n      = cur_a;
    cur_b_n      = cur_b;
    cur_sgn_n    = cur_sgn;
`endif

    // {rem,quo} acts as one double-width shift register; quo fills from the right.
    work_rem = rem;
    work_quo = quo;
    shifted  = '0;
    for (int unsigned i = 0; i < STEPS_PER_CYCLE; i++) begin
      shifted  = {work_rem, work_quo[XLEN-1]};
      work_quo = {work_quo[XLEN-2:0], 1'b0};
      if (shifted >= {1'b0, dvs}) begin
        work_rem    = XLEN'(shifted - {1'b0, dvs});
        work_quo[0] = 1'b1;
      end else begin
        work_rem = shifted[XLEN-1:0];
      end
    end

    case (state)
      IDLE: begin
        if (bus.req_valid) begin
          op_n    = bus.req_op;
          neg_q_n = signed_op & (bus.rs1[XLEN-1] ^ bus.rs2[XLEN-1]);
          neg_r_n = signed_op & bus.rs1[XLEN-1];
          dvs_n   = abs_b;
          quo_n   = abs_a;
          rem_n   = '0;
          cnt_n   = CNT_INIT;
          state_n = BUSY;
`ifdef EXEC_DIV_RESULT_REUSE_EN
          cur_a_n   = bus.rs1;
          cur_b_n   = bus.rs2;
          cur_sgn_n = signed_op;
`endif
          // Special cases store final values directly with sign correction disabled.
          if (bus.rs2 == '0) begin
            state_n = DONE;
            cnt_n   = '0;
            quo_n   = '1;
            rem_n   = bus.rs1;
            neg_q_n = 1'b0;
            neg_r_n = 1'b0;
          end else if (is_ovf) begin
            state_n = DONE;
            cnt_n   = '0;
            quo_n   = MIN_VAL;
            rem_n   = '0;
            neg_q_n = 1'b0;
            neg_r_n = 1'b0;
          end
`ifdef EXEC_DIV_RESULT_REUSE_EN
          if (reuse_hit) begin
            state_n = DONE;
            cnt_n   = '0;
            quo_n   = last_q;
            rem_n   = last_r;
            neg_q_n = 1'b0;
            neg_r_n = 1'b0;
          end
`endif
        end
      end
      BUSY: begin
        if (!bus.req_valid) begin
          state_n = IDLE;
          cnt_n   = '0;
        end else begin
          quo_n = work_quo;
          rem_n = work_rem;
          cnt_n = cnt - 1'b1;
          if (cnt == CNT_W'(1)) state_n = DONE;
        end
      end
      DONE: begin
        state_n = IDLE;
`ifdef EXEC_DIV_RESULT_REUSE_EN
        last_valid_n = 1'b1;
        last_a_n     = cur_a;
        last_b_n     = cur_b;
        last_sgn_n   = cur_sgn;
        last_q_n     = q_fin;
        last_r_n     = r_fin;
`endif
      end
      default: state_n = IDLE;
    endcase

    if (bus.flush) begin
      state_n = IDLE;
      cnt_n   = '0;
`ifdef EXEC_DIV_RESULT_REUSE_EN
      last_valid_n = 1'b0;
`endif
    end
  end

  // Pipe registers in this core update on the falling edge.
  always_ff @(negedge clk) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
      rem   <= '0;
      quo   <= '0;
      dvs   <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      op    <= '0;
`ifdef EXEC_DIV_RESULT_REUSE_EN
      last_valid <= 1'b0;
      last_a     <= '0;
      last_b     <= '0;
      last_sgn   <= 1'b0;
      last_q     <= '0;
      last_r     <= '0;
      cur_a      <= '0;
      cur_b      <= '0;
      cur_sgn    <= 1'b0;
`endif
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      rem   <= rem_n;
      quo   <= quo_n;
      dvs   <= dvs_n;
      neg_q <= neg_q_n;
      neg_r <= neg_r_n;
      op    <= op_n;
`ifdef EXEC_DIV_RESULT_REUSE_EN
      last_valid <= last_valid_n;
      last_a     <= last_a_n;
      last_b     <= last_b_n;
      last_sgn   <= last_sgn_n;
      last_q     <= last_q_n;
      last_r     <= last_r_n;
      cur_a      <= cur_a_n;
      cur_b      <= cur_b_n;
      cur_sgn    <= cur_sgn_n;
`endif
    end
  end

endmodule

// File: tb/tb_exec_div_sequencer.sv
// Randomized self-checking bench for exec_div_sequencer against an arithmetic reference model.
module tb_exec_div_sequencer;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned S      = 1;
  localparam int          NORMAL = 1 + XLEN / S;

  localparam logic [1:0] OP_DIV  = 2'd0;
  localparam logic [1:0] OP_DIVU = 2'd1;
  localparam logic [1:0] OP_REM  = 2'd2;
  localparam logic [1:0] OP_REMU = 2'd3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;

  // Last completed operation, as the reuse store should remember it.
  bit          m_valid = 1'b0;
  logic [31:0] m_a, m_b;
  bit          m_sgn;

  exec_div_sequencer_if #(.XLEN(XLEN)) dif ();

  exec_div_sequencer #(.XLEN(XLEN), .STEPS_PER_CYCLE(S)) dut (
    .clk (clk),
    .rst (rst),
    .bus (dif)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ref_result(input logic [1:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
    logic [31:0] q, r;
    int sa, sb;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = a;
    end else if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000;
      r = 32'd0;
    end else if (!op[0]) begin
      sa = a;
      sb = b;
      q  = sa / sb;
      r  = sa % sb;
    end else begin
      q = a / b;
      r = a % b;
    end
    return op[1] ? r : q;
  endfunction

  function automatic int exp_stalls(input logic [1:0] op, input logic [31:0] a,
                                    input logic [31:0] b);
`ifdef EXEC_DIV_RESULT_REUSE_EN
    if (m_valid && a == m_a && b == m_b && (!op[0]) == m_sgn) return 1;
`endif
    if (b == 32'd0) return 1;
    if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return NORMAL;
  endfunction

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      dif.req_valid = 1'b0;
      dif.flush     = 1'b0;
    end
  endtask

  // Issues one op starting in the next cycle and follows it through to its result cycle.
  task automatic do_divide(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                           input string tag);
    logic [31:0] want, res;
    int          want_st, stalls;
    bit          got;
    logic        st_done;
    want    = ref_result(op, a, b);
    want_st = exp_stalls(op, a, b);
    res     = '0;
    st_done = 1'b0;
    stalls  = 0;
    got     = 1'b0;
    @(posedge clk);
    dif.req_valid = 1'b1;
    dif.req_op    = op;
    dif.rs1       = a;
    dif.rs2       = b;
    dif.flush     = 1'b0;
    for (int c = 0; c < 120 && !got; c++) begin
      if (c != 0) @(posedge clk);
      #1;
      if (dif.result_valid === 1'b1) begin
        got     = 1'b1;
        res     = dif.result;
        st_done = dif.stall;
      end else if (dif.stall === 1'b1) begin
        stalls++;
      end
    end
    vectors++;
    if (!got) begin
      miscompares++;
      $display("FAIL %s timeout: result_valid never seen (op=%0d a=%h b=%h)", tag, op, a, b);
    end else begin
      vectors++;
      if (res !== want) begin
        miscompares++;
        $display("FAIL %s result: got %h want %h (op=%0d a=%h b=%h)", tag, res, want, op, a, b);
      end
      vectors++;
      if (stalls != want_st) begin
        miscompares++;
        $display("FAIL %s stall_cycles: got %0d want %0d (op=%0d a=%h b=%h)",
                 tag, stalls, want_st, op, a, b);
      end
      vectors++;
      if (st_done !== 1'b0) begin
        miscompares++;
        $display("FAIL %s stall_in_done: got %b want 0", tag, st_done);
      end
      m_valid = 1'b1;
      m_a     = a;
      m_b     = b;
      m_sgn   = !op[0];
    end
  endtask

  task automatic watch_no_result(input int n, input string tag);
    int seen = 0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      dif.req_valid = 1'b0;
      dif.flush     = 1'b0;
      #1;
      if (dif.result_valid !== 1'b0) seen++;
    end
    vectors++;
    if (seen != 0) begin
      miscompares++;
      $display("FAIL %s no_result: result_valid seen %0d cycles want 0", tag, seen);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    dif.req_valid = 1'b0;
    dif.flush     = 1'b0;
    dif.req_op    = '0;
    dif.rs1       = '0;
    dif.rs2       = '0;
    repeat (3) @(posedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    vectors++;
    if (dif.stall !== 1'b0) begin
      miscompares++;
      $display("FAIL reset stall: got %b want 0", dif.stall);
    end
    vectors++;
    if (dif.result_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL reset result_valid: got %b want 0", dif.result_valid);
    end
    vectors++;
    if (dif.result !== 32'd0) begin
      miscompares++;
      $display("FAIL reset result: got %h want 0", dif.result);
    end
    m_valid = 1'b0;
  endtask

  task automatic test_directed();
    do_divide(OP_DIVU, 32'd100, 32'd7, "divu_100_7");
    idle(2);
    do_divide(OP_REM, 32'hFFFF_FFF9, 32'd2, "rem_m7_2");
    idle(1);
    do_divide(OP_DIV, 32'hFFFF_FFF9, 32'd2, "div_m7_2");
    idle(1);
    do_divide(OP_DIV, 32'd5, 32'd0, "div_by_zero");
    idle(1);
    do_divide(OP_REMU, 32'd5, 32'd0, "remu_by_zero");
    idle(1);
    do_divide(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
    idle(1);
    do_divide(OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, "rem_ovf");
    idle(1);
    do_divide(OP_DIVU, 32'hFFFF_FFFF, 32'hFFFF_FFFE, "divu_large");
    idle(1);
    do_divide(OP_DIV, 32'd100, 32'd7, "div_100_7");
    idle(1);
    do_divide(OP_REM, 32'd100, 32'd7, "rem_100_7_reuse");
    idle(1);
  endtask

  task automatic test_flush();
    int st_before = 0;
    @(posedge clk);
    dif.req_valid = 1'b1;
    dif.req_op    = OP_DIVU;
    dif.rs1       = 32'd100;
    dif.rs2       = 32'd7;
    dif.flush     = 1'b0;
    for (int i = 0; i < 11; i++) begin
      if (i != 0) @(posedge clk);
      #1;
      if (dif.stall === 1'b1 && dif.result_valid === 1'b0) st_before++;
    end
    vectors++;
    if (st_before != 11) begin
      miscompares++;
      $display("FAIL flush pre_stall: got %0d stalled cycles want 11", st_before);
    end
    @(posedge clk);
    dif.flush = 1'b1;
    #1;
    vectors++;
    if (dif.stall !== 1'b0 || dif.result_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL flush cycle: stall=%b result_valid=%b want 0/0", dif.stall, dif.result_valid);
    end
    m_valid = 1'b0;
    watch_no_result(40, "flush");
    do_divide(OP_DIVU, 32'd9, 32'd3, "divu_after_flush");
    idle(1);
  endtask

  task automatic test_abort();
    @(posedge clk);
    dif.req_valid = 1'b1;
    dif.req_op    = OP_DIV;
    dif.rs1       = 32'd1000;
    dif.rs2       = 32'd3;
    repeat (6) @(posedge clk);
    dif.req_valid = 1'b0;
    watch_no_result(40, "abort");
    do_divide(OP_DIV, 32'd1000, 32'd3, "div_after_abort");
    idle(1);
  endtask

  task automatic test_reset_mid_op();
    @(posedge clk);
    dif.req_valid = 1'b1;
    dif.req_op    = OP_REMU;
    dif.rs1       = 32'd12345;
    dif.rs2       = 32'd17;
    repeat (5) @(posedge clk);
    rst = 1'b0;
    dif.req_valid = 1'b0;
    @(posedge clk);
    rst = 1'b1;
    m_valid = 1'b0;
    watch_no_result(40, "reset_mid_op");
    do_divide(OP_REMU, 32'd12345, 32'd17, "remu_after_reset");
    idle(1);
  endtask

  task automatic test_random_back_to_back();
    logic [1:0]  op;
    logic [31:0] a, b;
    a = 32'd1;
    b = 32'd1;
    for (int n = 0; n < 60; n++) begin
      op = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 9))
        0: begin a = $urandom; b = 32'd0; end
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: begin end
        3: begin a = $urandom_range(0, 300); b = $urandom_range(1, 20); end
        4: begin a = -$urandom_range(0, 300); b = $urandom_range(1, 20); end
        5: begin a = $urandom; b = -$urandom_range(1, 50); end
        default: begin a = $urandom; b = $urandom >> $urandom_range(0, 31); end
      endcase
      do_divide(op, a, b, "random");
    end
    idle(2);
  endtask

  initial begin
    dif.req_valid = 1'b0;
    dif.req_op    = '0;
    dif.rs1       = '0;
    dif.rs2       = '0;
    dif.flush     = 1'b0;
    test_reset();
    test_directed();
    test_flush();
    test_abort();
    test_reset_mid_op();
    test_random_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
